irq_timer_src: RTL and testbench
================================

# irq_timer_src

Machine-timer and external-interrupt source that drives the `MTI`/`EI` request inputs of the core's CSR register file. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a control/status block on a small word-addressed register bus. It also synchronises and edge-detects an asynchronous external interrupt pin. Each request is held pending until the core acknowledges it, which gives the CSR side one clean, single-owner request per event.

## Interface
- `EXT_SYNC_STAGES`, default 2: synchroniser depth on `ext_irq_in`; legal values are 2 or 3.
- `clk` in 1: single system clock; everything samples on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `addr` in 5: byte address of the register; bits [1:0] are ignored.
- `wdata` in 32: write data.
- `reg_write` in 1: write strobe, one word per cycle.
- `reg_rd` in 1: read strobe.
- `rdata` out 32: combinational read data; 0 when `reg_rd`=0 or the address is unmapped.
- `ext_irq_in` in 1: asynchronous external interrupt pin, active-high.
- `mti_ack` in 1: core has taken the timer interrupt.
- `ei_ack` in 1: core has taken the external interrupt.
- `MTI` out 1: timer interrupt pending (level).
- `EI` out 1: external interrupt pending (level).

## Operation
- Register map:
  - 0x00 `mtime_lo` (RW).
  - 0x04 `mtime_hi` (RW; reads return the snapshot).
  - 0x08 `mtimecmp_lo` (RW).
  - 0x0C `mtimecmp_hi` (RW).
  - 0x10 `ctrl` (RW): [0] timer_en, [1] ei_en, [15:8] prescale.
  - 0x14 `status` (R/W1C): [0] MTI pending, [1] EI pending.
- `mtime`:
  - Increments by 1 on each prescaler tick while timer_en=1.
  - Wraps from 2^64-1 to 0.
  - A write to `mtime_lo`/`mtime_hi` replaces that half in the same edge and suppresses the increment for that cycle.
- Snapshot: a read of `mtime_lo` (`reg_rd` and addr 0x00) latches `mtime[63:32]` into a shadow register at the edge. `mtime_hi` reads return the shadow.
- Compare:
  - `cmp` = (`mtime` >= `mtimecmp`), 64-bit unsigned; `cmp_q` is its registered copy.
  - Timer event = `cmp` && !`cmp_q` && timer_en.
  - A write to either `mtimecmp` half clears `MTI` and forces `cmp_q` to 0, so a new compare value already ≤ `mtime` raises `MTI` on the next edge.
- External interrupt:
  - `ext_irq_in` passes through `EXT_SYNC_STAGES` flops, followed by one edge-detect flop.
  - A rising edge with ei_en=1 sets `EI`.
  - A level held high generates only one event.
- Pending flags (`MTI`, `EI`) are set by their event.
  - Cleared by the matching ack, or by a W1C write of 1 to the `status` bit.
  - Set and clear in the same cycle: set wins.
  - Ack while not pending: no effect.
  - Clearing timer_en or ei_en does not clear a flag that is already pending.
- `MTI` and `EI` are independent; both may be high together. Priority between them is the CSR file's concern.

## Timing
- Reset (async assert, sync release):
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, shadow=0, prescaler=0.
  - `cmp_q`=0, synchroniser flops 0, `MTI`=0, `EI`=0. `rdata`=0 while `reg_rd`=0.
- Reset asserted mid-count or mid-request discards all state immediately.
- Prescaler:
  - Tick every prescale+1 cycles; prescale=0 ticks every cycle.
  - A `ctrl` write restarts the prescaler count at 0.
- Timer latency: `MTI` rises on the first posedge after `mtime` reaches `mtimecmp` (`cmp` true on cycle N, `MTI`=1 from N+1).
- External latency: `EI` rises EXT_SYNC_STAGES+1 edges after the first posedge that samples `ext_irq_in` high.
- Ack or W1C: flag is low starting the cycle after the edge on which it is sampled.
- Writes take effect at the posedge; reads are combinational on current register state.

## Configuration
- `IRQ_TIMER_PRESCALER_EN` defined:
  - The prescaler counter exists.
  - `ctrl[15:8]` is writable and reads back its stored value.
- Not defined:
  - No prescaler logic; `mtime` ticks every cycle while timer_en=1.
  - `ctrl[15:8]` is write-ignored and reads 0.

## Test plan
- Timer event and ack:
  - Stimulus: after reset, write mtimecmp=0x0000_0000_0000_0010, ctrl=0x1.
  - Required: `MTI` rises exactly one cycle after `mtime`=0x10 and stays high; `mti_ack` pulse → `MTI`=0 next cycle, with no re-assert while `mtime` keeps counting.
- Rewrite below current time:
  - Stimulus: `mtime`=0x100, then write mtimecmp_lo=0x50.
  - Required: `MTI`=1 on the following edge.
- Prescaler (macro defined):
  - Stimulus: ctrl=0x0301.
  - Required: `mtime` increments once every 4 cycles.
  - Without the macro: readback of ctrl is 0x0001.
- Wrap and snapshot:
  - Stimulus: set mtime=0xFFFF_FFFF_FFFF_FFFE with timer_en=1; after 2 ticks, read lo then hi.
  - Required: lo=0, hi=0; read mtime_lo with the value 0x0000_0001_FFFF_FFFF pending a carry → hi read returns 1 even after the carry.
- External edge:
  - Stimulus: ei_en=1; hold `ext_irq_in` high for 10 cycles.
  - Required: `EI` rises 3 edges after the first sample, exactly once; a W1C write of 0x2 to status clears it; `ei_ack` in the same cycle as a new edge leaves `EI`=1.
- Reset mid-request:
  - Stimulus: with `MTI`=`EI`=1, pulse `reset_n` low between clock edges.
  - Required: both outputs are 0 immediately, and all registers hold their reset values.

Source files
------------

// File: rtl/irq_timer_src.sv
// irq_timer_src: machine timer (64-bit mtime/mtimecmp) plus a synchronised,
// edge-detected external interrupt. It provides the MTI/EI request levels for
// the CSR register file.
// Optional feature macro: IRQ_TIMER_PRESCALER_EN adds a programmable mtime
// prescaler in ctrl[15:8]. Without it, mtime ticks every enabled cycle and
// ctrl[15:8] reads 0.
//
// Bus and request semantics:
//   reg_write: one word is written at the posedge where it is sampled high.
//   reg_rd:    rdata is combinational and reflects the current state. It is 0
//              when reg_rd is low or the address is unmapped. A read of
//              mtime_lo also latches mtime[63:32] into the hi shadow at that
//              edge.
//   MTI/EI:    these are levels that stay high until mti_ack/ei_ack or a W1C
//              status write is sampled. If a new event arrives on the same
//              edge as a clear, the event wins.
module irq_timer_src #(
  parameter int EXT_SYNC_STAGES = 2  // 2 or 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        reg_write,
  input  logic        reg_rd,
  output logic [31:0] rdata,
  input  logic        ext_irq_in,
  input  logic        mti_ack,
  input  logic        ei_ack,
  output logic        MTI,
  output logic        EI
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow;
  logic        r_timer_en;
  logic        r_ei_en;
  logic        r_cmp_q;
  logic        r_mti;
  logic        r_ei;
  logic [EXT_SYNC_STAGES-1:0] r_sync;
  logic        r_ext_q;
  logic        r_ext_edge;

  logic [2:0]  w_word;
  logic        w_wr_mtime_lo, w_wr_mtime_hi, w_wr_cmp_lo, w_wr_cmp_hi;
  logic        w_wr_cmp, w_wr_ctrl, w_wr_status;
  logic        w_tick;
  logic        w_cmp;
  logic        w_timer_evt;
  logic        w_ei_evt;
  logic        w_sync_out;
  logic [7:0]  w_prescale_rd;
  logic        w_unused_addr;

  // The bus is word addressed, so the byte-offset bits are deliberately ignored.
  assign w_unused_addr = ^addr[1:0];
  assign w_word        = addr[4:2];

  assign w_wr_mtime_lo = reg_write && (w_word == 3'd0);
  assign w_wr_mtime_hi = reg_write && (w_word == 3'd1);
  assign w_wr_cmp_lo   = reg_write && (w_word == 3'd2);
  assign w_wr_cmp_hi   = reg_write && (w_word == 3'd3);
  assign w_wr_ctrl     = reg_write && (w_word == 3'd4);
  assign w_wr_status   = reg_write && (w_word == 3'd5);
  assign w_wr_cmp      = w_wr_cmp_lo || w_wr_cmp_hi;

`ifdef IRQ_TIMER_PRESCALER_EN
  logic [7:0] r_prescale;
  logic [7:0] r_presc_cnt;

  // Holds the prescale value; it is loaded together with the other ctrl fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_prescale <= 8'h00;
    else if (w_wr_ctrl) r_prescale <= wdata[15:8];
  end

  // Prescaler counter: a tick is produced every prescale+1 enabled cycles. A ctrl write restarts the count at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_presc_cnt <= 8'h00;
    else if (w_wr_ctrl)  r_presc_cnt <= 8'h00;
    else if (r_timer_en) r_presc_cnt <= w_tick ? 8'h00 : r_presc_cnt + 8'd1;
  end

  assign w_tick        = (r_presc_cnt == r_prescale);
  assign w_prescale_rd = r_prescale;
`else
  assign w_tick        = 1'b1;
  assign w_prescale_rd = 8'h00;
`endif

  // Control bits: the timer enable and the external interrupt enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer_en <= 1'b0;
      r_ei_en    <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_timer_en <= wdata[0];
      r_ei_en    <= wdata[1];
    end
  end

  // mtime: a bus write replaces one half and suppresses that cycle's increment. The counter wraps naturally at 2^64.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_mtime <= 64'h0;
    else if (w_wr_mtime_lo)        r_mtime[31:0]  <= wdata;
    else if (w_wr_mtime_hi)        r_mtime[63:32] <= wdata;
    else if (r_timer_en && w_tick) r_mtime <= r_mtime + 64'd1;
  end

  // mtimecmp halves. The reset value is all-ones, so the compare does not fire after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    else if (w_wr_cmp_lo)  r_mtimecmp[31:0]  <= wdata;
    else if (w_wr_cmp_hi)  r_mtimecmp[63:32] <= wdata;
  end

  // A read of mtime_lo captures the upper half, so a following hi read returns a consistent value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_shadow <= 32'h0;
    else if (reg_rd && (w_word == 3'd0))   r_shadow <= r_mtime[63:32];
  end

  assign w_cmp       = (r_mtime >= r_mtimecmp);
  assign w_timer_evt = w_cmp && !r_cmp_q && r_timer_en;

  // Registered compare. A compare write forces it low, so a new target that is already passed fires again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cmp_q <= 1'b0;
    else if (w_wr_cmp) r_cmp_q <= 1'b0;
    else               r_cmp_q <= w_cmp;
  end

  assign w_sync_out = r_sync[EXT_SYNC_STAGES-1];
  assign w_ei_evt   = r_ext_edge && r_ei_en;

  // External pin path: a synchroniser chain, a delayed copy for edge detection, and a registered rising-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_ext_q    <= 1'b0;
      r_ext_edge <= 1'b0;
    end else begin
      r_sync     <= {r_sync[EXT_SYNC_STAGES-2:0], ext_irq_in};
      r_ext_q    <= w_sync_out;
      r_ext_edge <= w_sync_out && !r_ext_q;
    end
  end

  // Pending timer flag: the event sets it and has priority over ack, W1C or a compare rewrite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          r_mti <= 1'b0;
    else if (w_timer_evt)                                  r_mti <= 1'b1;
    else if (mti_ack || (w_wr_status && wdata[0]) || w_wr_cmp) r_mti <= 1'b0;
  end

  // Pending external flag: the event sets it and has priority over ack or W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               r_ei <= 1'b0;
    else if (w_ei_evt)                          r_ei <= 1'b1;
    else if (ei_ack || (w_wr_status && wdata[1])) r_ei <= 1'b0;
  end

  assign MTI = r_mti;
  assign EI  = r_ei;

  // Combinational read mux. Unmapped words, and cycles without a read strobe, return 0.
  always_comb begin
    rdata = 32'h0;
    if (reg_rd) begin
      case (w_word)
        3'd0:    rdata = r_mtime[31:0];
        3'd1:    rdata = r_shadow;
        3'd2:    rdata = r_mtimecmp[31:0];
        3'd3:    rdata = r_mtimecmp[63:32];
        3'd4:    rdata = {16'h0, w_prescale_rd, 6'h0, r_ei_en, r_timer_en};
        3'd5:    rdata = {30'h0, r_ei, r_mti};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_src.sv
// tb_irq_timer_src: directed bench for irq_timer_src. The stimulus pushes the
// expected {MTI, EI, rdata} into exp_q for each checked cycle, and a negedge
// monitor pops and compares them.
module tb_irq_timer_src;

  localparam int W = 34;

`ifdef IRQ_TIMER_PRESCALER_EN
  localparam logic [31:0] CTRL_RB = 32'h0000_0301;
  localparam logic [31:0] PS_T4 = 32'd0, PS_T5 = 32'd1, PS_T8 = 32'd1, PS_T9 = 32'd2;
`else
  localparam logic [31:0] CTRL_RB = 32'h0000_0001;
  localparam logic [31:0] PS_T4 = 32'd1, PS_T5 = 32'd2, PS_T8 = 32'd5, PS_T9 = 32'd6;
`endif

  logic        clk;
  logic        reset_n;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        reg_write;
  logic        reg_rd;
  logic [31:0] rdata;
  logic        ext_irq_in;
  logic        mti_ack;
  logic        ei_ack;
  logic        MTI;
  logic        EI;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_valid;
  logic [W-1:0] exp_w;
  logic [W-1:0] got_w;
  string        cur_name;
  int           n_cmp;
  int           n_err;

  irq_timer_src #(.EXT_SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .wdata      (wdata),
    .reg_write  (reg_write),
    .reg_rd     (reg_rd),
    .rdata      (rdata),
    .ext_irq_in (ext_irq_in),
    .mti_ack    (mti_ack),
    .ei_ack     (ei_ack),
    .MTI        (MTI),
    .EI         (EI)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; reg_write = 1'b1;
    step();
    reg_write = 1'b0; wdata = 32'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] d,
                        input logic m, input logic e);
    addr = a; reg_rd = 1'b1;
    exp_q.push_back({m, e, d});
    name_q.push_back(nm);
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0; reg_rd = 1'b0;
  endtask

  // Checks the flags, and that rdata stays 0 while reg_rd is low, even on a mapped address.
  task automatic flags_chk(input string nm, input logic m, input logic e);
    addr = 5'h08; reg_rd = 1'b0;
    exp_q.push_back({m, e, 32'h0});
    name_q.push_back(nm);
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0;
  endtask

  task automatic check_reset_regs(input string p);
    rd_chk({p, "_mtime_hi"}, 5'h04, 32'h0, 1'b0, 1'b0);
    rd_chk({p, "_mtime_lo"}, 5'h00, 32'h0, 1'b0, 1'b0);
    rd_chk({p, "_cmp_lo"},   5'h08, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd_chk({p, "_cmp_hi"},   5'h0C, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd_chk({p, "_ctrl"},     5'h10, 32'h0, 1'b0, 1'b0);
    rd_chk({p, "_status"},   5'h14, 32'h0, 1'b0, 1'b0);
    rd_chk({p, "_unmapped"}, 5'h1C, 32'h0, 1'b0, 1'b0);
    flags_chk({p, "_rd_idle"}, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (chk_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL no_expectation: got {MTI,EI,rdata}=%h, need a queued entry", {MTI, EI, rdata});
      end else begin
        exp_w    = exp_q.pop_front();
        cur_name = name_q.pop_front();
        got_w    = {MTI, EI, rdata};
        if (got_w !== exp_w) begin
          n_err++;
          $display("FAIL %s: got MTI=%b EI=%b rdata=%h, need MTI=%b EI=%b rdata=%h",
                   cur_name, got_w[33], got_w[32], got_w[31:0],
                   exp_w[33], exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; chk_valid = 1'b0;
    reset_n = 1'b0; addr = 5'h0; wdata = 32'h0; reg_write = 1'b0; reg_rd = 1'b0;
    ext_irq_in = 1'b0; mti_ack = 1'b0; ei_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state.
    check_reset_regs("rst");

    // Timer event at mtime == 0x10, followed by an ack.
    wr(5'h08, 32'h10);
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'h1);
    wait_cycles(16);
    rd_chk("mti_pre",  5'h00, 32'h10, 1'b0, 1'b0);
    rd_chk("mti_rise", 5'h00, 32'h11, 1'b1, 1'b0);
    flags_chk("mti_hold", 1'b1, 1'b0);
    mti_ack = 1'b1; step(); mti_ack = 1'b0;
    flags_chk("mti_ack_clr", 1'b0, 1'b0);
    wait_cycles(5);
    flags_chk("mti_no_reassert", 1'b0, 1'b0);

    // Rewrite mtimecmp below the current time.
    wr(5'h00, 32'h100);
    wr(5'h08, 32'h50);
    flags_chk("rewrite_pre", 1'b0, 1'b0);
    rd_chk("rewrite_mti", 5'h00, 32'h102, 1'b1, 1'b0);
    rd_chk("status_mti",  5'h14, 32'h1, 1'b1, 1'b0);
    wr(5'h14, 32'h1);
    flags_chk("w1c_mti", 1'b0, 1'b0);

    // Prescaler: ctrl=0x0301.
    wr(5'h10, 32'h0301);
    rd_chk("ctrl_rb", 5'h10, CTRL_RB, 1'b0, 1'b0);
    wr(5'h00, 32'h0);
    wait_cycles(1);
    rd_chk("presc_t4", 5'h00, PS_T4, 1'b0, 1'b0);
    rd_chk("presc_t5", 5'h00, PS_T5, 1'b0, 1'b0);
    wait_cycles(2);
    rd_chk("presc_t8", 5'h00, PS_T8, 1'b0, 1'b0);
    rd_chk("presc_t9", 5'h00, PS_T9, 1'b0, 1'b0);
    wr(5'h10, 32'h1);

    // Wrap through 2^64 and check the hi snapshot.
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h08, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFE);
    wait_cycles(1);
    flags_chk("wrap_pre", 1'b0, 1'b0);
    rd_chk("wrap_lo", 5'h00, 32'h0, 1'b1, 1'b0);
    rd_chk("wrap_hi", 5'h04, 32'h0, 1'b1, 1'b0);
    mti_ack = 1'b1; step(); mti_ack = 1'b0;
    wr(5'h04, 32'h1);
    wr(5'h00, 32'hFFFF_FFFF);
    rd_chk("snap_lo",  5'h00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd_chk("snap_hi",  5'h04, 32'h1, 1'b0, 1'b0);
    rd_chk("snap_lo2", 5'h00, 32'h1, 1'b0, 1'b0);
    rd_chk("snap_hi2", 5'h04, 32'h2, 1'b0, 1'b0);

    // External interrupt edge.
    wr(5'h10, 32'h2);
    ext_irq_in = 1'b1; step();
    wait_cycles(2);
    flags_chk("ei_pre",  1'b0, 1'b0);
    flags_chk("ei_rise", 1'b0, 1'b1);
    wr(5'h14, 32'h2);
    flags_chk("ei_w1c", 1'b0, 1'b0);
    wait_cycles(3);
    ext_irq_in = 1'b0;
    flags_chk("ei_level_once", 1'b0, 1'b0);
    wait_cycles(2);
    ext_irq_in = 1'b1; step();
    wait_cycles(2);
    flags_chk("ei_edge2_pre", 1'b0, 1'b0);
    flags_chk("ei_edge2",     1'b0, 1'b1);
    ext_irq_in = 1'b0; wait_cycles(2);
    ext_irq_in = 1'b1; step();
    wait_cycles(2);
    ei_ack = 1'b1;
    flags_chk("ei_ack_evt", 1'b0, 1'b1);
    ei_ack = 1'b0;
    flags_chk("ei_set_wins", 1'b0, 1'b1);
    ei_ack = 1'b1; step(); ei_ack = 1'b0;
    flags_chk("ei_ack_clr", 1'b0, 1'b0);

    // Reset asserted while both requests are pending.
    ext_irq_in = 1'b0;
    wr(5'h10, 32'h3);
    wr(5'h0C, 32'h0);
    ext_irq_in = 1'b1; step();
    wait_cycles(3);
    flags_chk("pre_reset", 1'b1, 1'b1);
    reset_n = 1'b0;
    ext_irq_in = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    name_q.push_back("reset_async");
    chk_valid = 1'b1;
    @(negedge clk);
    #1;
    chk_valid = 1'b0;
    reset_n = 1'b1;
    step();
    check_reset_regs("post");

    wait_cycles(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries left, need 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
